// File: rtl/fpu_shared_unit_arbiter.sv
// ----------------------------------------------------------------------------
// fpu_shared_unit_arbiter
//   Shares one FPU AddSub unit and one FPU MulDiv unit between NREQ
//   requesters (main arithmetic path, polynomial evaluator, transcendental
//   sequencer). Each side latches one pending operation per requester, serves
//   the pending slots round-robin one at a time, and routes the unit result
//   back as a one-hot done pulse. A watchdog completes a hung unit with the
//   x87 indefinite value and the invalid flag.
//
// Ports (AddSub side as_*, MulDiv side md_*; both sides identical):
//   clk, reset_n                 clock, async active-low reset
//   *_req  [NREQ]                one-cycle request pulse per requester
//   *_a, *_b [NREQ*80]           packed operands, requester i at [80i+79:80i]
//   as_sub / md_div [NREQ]       operation bit per requester
//   *_done [NREQ]                one-hot completion pulse
//   *_result [80], *_flags [4]   completion data {inv, ovf, unf, inx}
//   *_unit_enable/a/b/sub|div    start pulse and operands to the shared unit
//   *_unit_result/done/flags     unit response
//   *_busy                       side not idle or any slot pending
//   protocol_err                 pulse when a request hits an occupied slot
// ----------------------------------------------------------------------------

// One arbitration side: pending slots, round-robin pick, issue/wait FSM.
module fpu_arb_side #(
    parameter int NREQ           = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*80-1:0]   i_a,
    input  logic [NREQ*80-1:0]   i_b,
    input  logic [NREQ-1:0]      i_op,
    output logic [NREQ-1:0]      o_done,
    output logic [79:0]          o_result,
    output logic [3:0]           o_flags,
    output logic                 o_unit_enable,
    output logic [79:0]          o_unit_a,
    output logic [79:0]          o_unit_b,
    output logic                 o_unit_op,
    input  logic [79:0]          i_unit_result,
    input  logic                 i_unit_done,
    input  logic [3:0]           i_unit_flags,
    output logic                 o_busy,
    output logic                 o_perr
);
    localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_ISSUE = 2'd1;
    localparam logic [1:0]  S_WAIT  = 2'd2;
    localparam logic [79:0] INDEF   = 80'hFFFF_C000_0000_0000_0000;

    logic [1:0]             r_state;
    logic [PW-1:0]          r_ptr, r_gnt;
    logic [15:0]            r_cnt;
    logic [NREQ-1:0]        r_vld, r_op;
    logic [NREQ-1:0][79:0]  r_a, r_b;
    logic                   r_en, r_uop, r_perr;
    logic [79:0]            r_ua, r_ub, r_result;
    logic [3:0]             r_flags;
    logic [NREQ-1:0]        r_done;

    logic                   w_found, w_grant;
    logic [PW-1:0]          w_pick;
    logic [NREQ-1:0]        w_clr, w_acc, w_rej;

    // First valid slot after ptr. Scanning the search order backwards lets
    // the last hit (the nearest one) win without a break.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = PW'((int'(r_ptr) + k) % NREQ);
            if (r_vld[idx]) begin
                w_found = 1'b1;
                w_pick  = idx;
            end
        end
    end

    assign w_grant = (r_state == S_IDLE) && w_found;
    assign w_clr   = w_grant ? (NREQ'(1) << w_pick) : '0;
    // A slot emptied by this edge's grant may take a new request on the same edge.
    assign w_acc   = i_req & (~r_vld | w_clr);
    assign w_rej   = i_req & r_vld & ~w_clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_acc[i]) begin
                    r_vld[i] <= 1'b1;
                    r_op[i]  <= i_op[i];
                    r_a[i]   <= i_a[80*i +: 80];
                    r_b[i]   <= i_b[80*i +: 80];
                end else if (w_clr[i]) begin
                    r_vld[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= PW'(NREQ - 1);
            r_gnt    <= '0;
            r_cnt    <= '0;
            r_en     <= 1'b0;
            r_ua     <= '0;
            r_ub     <= '0;
            r_uop    <= 1'b0;
            r_done   <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_perr   <= 1'b0;
        end else begin
            r_en   <= 1'b0;
            r_done <= '0;
            r_perr <= |w_rej;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_pick;
                        r_ptr   <= w_pick;
                        r_ua    <= r_a[w_pick];
                        r_ub    <= r_b[w_pick];
                        r_uop   <= r_op[w_pick];
                        r_en    <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A real completion wins over a coincident timeout.
                    if (i_unit_done) begin
                        r_result <= i_unit_result;
                        r_flags  <= i_unit_flags;
                        r_done   <= NREQ'(1) << r_gnt;
                        r_state  <= S_IDLE;
                    end else if (r_cnt == 16'(TIMEOUT_CYCLES)) begin
                        r_result <= INDEF;
                        r_flags  <= 4'b1000;
                        r_done   <= NREQ'(1) << r_gnt;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_done        = r_done;
    assign o_result      = r_result;
    assign o_flags       = r_flags;
    assign o_unit_enable = r_en;
    assign o_unit_a      = r_ua;
    assign o_unit_b      = r_ub;
    assign o_unit_op     = r_uop;
    assign o_busy        = (r_state != S_IDLE) || (|r_vld);
    assign o_perr        = r_perr;
endmodule

module fpu_shared_unit_arbiter #(
    parameter int NREQ           = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      as_req,
    input  logic [NREQ*80-1:0]   as_a,
    input  logic [NREQ*80-1:0]   as_b,
    input  logic [NREQ-1:0]      as_sub,
    output logic [NREQ-1:0]      as_done,
    output logic [79:0]          as_result,
    output logic [3:0]           as_flags,
    output logic                 as_unit_enable,
    output logic [79:0]          as_unit_a,
    output logic [79:0]          as_unit_b,
    output logic                 as_unit_sub,
    input  logic [79:0]          as_unit_result,
    input  logic                 as_unit_done,
    input  logic [3:0]           as_unit_flags,
    output logic                 as_busy,
    input  logic [NREQ-1:0]      md_req,
    input  logic [NREQ*80-1:0]   md_a,
    input  logic [NREQ*80-1:0]   md_b,
    input  logic [NREQ-1:0]      md_div,
    output logic [NREQ-1:0]      md_done,
    output logic [79:0]          md_result,
    output logic [3:0]           md_flags,
    output logic                 md_unit_enable,
    output logic [79:0]          md_unit_a,
    output logic [79:0]          md_unit_b,
    output logic                 md_unit_div,
    input  logic [79:0]          md_unit_result,
    input  logic                 md_unit_done,
    input  logic [3:0]           md_unit_flags,
    output logic                 md_busy,
    output logic                 protocol_err
);
    logic w_as_perr, w_md_perr;

    fpu_arb_side #(.NREQ(NREQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_as (
        .clk(clk), .reset_n(reset_n),
        .i_req(as_req), .i_a(as_a), .i_b(as_b), .i_op(as_sub),
        .o_done(as_done), .o_result(as_result), .o_flags(as_flags),
        .o_unit_enable(as_unit_enable), .o_unit_a(as_unit_a),
        .o_unit_b(as_unit_b), .o_unit_op(as_unit_sub),
        .i_unit_result(as_unit_result), .i_unit_done(as_unit_done),
        .i_unit_flags(as_unit_flags), .o_busy(as_busy), .o_perr(w_as_perr)
    );

    fpu_arb_side #(.NREQ(NREQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_md (
        .clk(clk), .reset_n(reset_n),
        .i_req(md_req), .i_a(md_a), .i_b(md_b), .i_op(md_div),
        .o_done(md_done), .o_result(md_result), .o_flags(md_flags),
        .o_unit_enable(md_unit_enable), .o_unit_a(md_unit_a),
        .o_unit_b(md_unit_b), .o_unit_op(md_unit_div),
        .i_unit_result(md_unit_result), .i_unit_done(md_unit_done),
        .i_unit_flags(md_unit_flags), .o_busy(md_busy), .o_perr(w_md_perr)
    );

    // Both per-side error pulses are already registered.
    assign protocol_err = w_as_perr | w_md_perr;
endmodule

// File: tb/tb_fpu_shared_unit_arbiter.sv
module tb_fpu_shared_unit_arbiter;
    localparam int NREQ = 3;
    localparam int TO   = 255;
    localparam logic [79:0] ONE   = 80'h3FFF_8000_0000_0000_0000;
    localparam logic [79:0] TWO   = 80'h4000_8000_0000_0000_0000;
    localparam logic [79:0] THREE = 80'h4000_C000_0000_0000_0000;
    localparam logic [79:0] INDEF = 80'hFFFF_C000_0000_0000_0000;

    logic clk, reset_n;
    logic [NREQ-1:0] as_req, as_sub, as_done, md_req, md_div, md_done;
    logic [NREQ*80-1:0] as_a, as_b, md_a, md_b;
    logic [79:0] as_result, as_unit_a, as_unit_b, as_unit_result;
    logic [79:0] md_result, md_unit_a, md_unit_b, md_unit_result;
    logic [3:0]  as_flags, as_unit_flags, md_flags, md_unit_flags;
    logic as_unit_enable, as_unit_sub, as_unit_done, as_busy;
    logic md_unit_enable, md_unit_div, md_unit_done, md_busy, protocol_err;

    fpu_shared_unit_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .as_req(as_req), .as_a(as_a), .as_b(as_b), .as_sub(as_sub),
        .as_done(as_done), .as_result(as_result), .as_flags(as_flags),
        .as_unit_enable(as_unit_enable), .as_unit_a(as_unit_a), .as_unit_b(as_unit_b),
        .as_unit_sub(as_unit_sub), .as_unit_result(as_unit_result),
        .as_unit_done(as_unit_done), .as_unit_flags(as_unit_flags), .as_busy(as_busy),
        .md_req(md_req), .md_a(md_a), .md_b(md_b), .md_div(md_div),
        .md_done(md_done), .md_result(md_result), .md_flags(md_flags),
        .md_unit_enable(md_unit_enable), .md_unit_a(md_unit_a), .md_unit_b(md_unit_b),
        .md_unit_div(md_unit_div), .md_unit_result(md_unit_result),
        .md_unit_done(md_unit_done), .md_unit_flags(md_unit_flags), .md_busy(md_busy),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Unit models: mode 0 answers L cycles after sampling enable, mode 1
    // answers far too late (after the watchdog), mode 2 never answers.
    // Result = a ^ b (or fixed 3.0 when as_fix), flags = a[3:0].
    int as_lat = 5, md_lat = 1, as_mode = 0, md_mode = 0;
    logic as_fix = 1'b0;
    logic [79:0] as_ra, md_ra;
    logic [3:0]  as_rf, md_rf;

    initial begin
        as_unit_done = 1'b0; as_unit_result = '0; as_unit_flags = '0;
        forever begin
            @(negedge clk);
            if (as_unit_enable && as_mode != 2) begin
                as_ra = as_fix ? THREE : (as_unit_a ^ as_unit_b);
                as_rf = as_unit_a[3:0];
                repeat ((as_mode == 1 ? 300 : as_lat) + 1) @(posedge clk);
                #1 as_unit_result = as_ra; as_unit_flags = as_rf; as_unit_done = 1'b1;
                @(posedge clk);
                #1 as_unit_done = 1'b0;
            end
        end
    end

    initial begin
        md_unit_done = 1'b0; md_unit_result = '0; md_unit_flags = '0;
        forever begin
            @(negedge clk);
            if (md_unit_enable && md_mode != 2) begin
                md_ra = md_unit_a ^ md_unit_b;
                md_rf = md_unit_a[3:0];
                repeat ((md_mode == 1 ? 300 : md_lat) + 1) @(posedge clk);
                #1 md_unit_result = md_ra; md_unit_flags = md_rf; md_unit_done = 1'b1;
                @(posedge clk);
                #1 md_unit_done = 1'b0;
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        as_req = '0; md_req = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    logic [79:0] exp_md_res [3];
    logic [3:0]  exp_md_flg [3];
    logic [79:0] got_res [3];
    logic [3:0]  got_flg [3];
    logic [NREQ-1:0] got_done [3];
    logic got_div [3];
    int glog [8];
    logic [79:0] ua_log [4];
    int ng, nd, nperr, nen, ndone;
    logic [79:0] r0;

    initial begin
        reset_n = 1'b0;
        as_req = '0; as_sub = '0; as_a = '0; as_b = '0;
        md_req = '0; md_div = '0; md_a = '0; md_b = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_as_done", 80'(as_done), 80'h0);
        chk("rst_as_en", 80'(as_unit_enable), 80'h0);
        chk("rst_as_busy", 80'(as_busy), 80'h0);
        chk("rst_md_busy", 80'(md_busy), 80'h0);
        chk("rst_perr", 80'(protocol_err), 80'h0);
        chk("rst_md_result", md_result, 80'h0);
        chk("rst_as_unit_a", as_unit_a, 80'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // T1: requester 1 on AddSub, 1.0 + 2.0, unit latency 5
        as_fix = 1'b1; as_lat = 5; nen = 0;
        as_a[80 +: 80] = ONE; as_b[80 +: 80] = TWO; as_sub = 3'b000; as_req = 3'b010;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            as_req = '0;
            if (as_unit_enable) nen++;
            if (k == 1) chk("t1_busy", 80'(as_busy), 80'h1);
            if (k == 2) begin
                chk("t1_en", 80'(as_unit_enable), 80'h1);
                chk("t1_unit_a", as_unit_a, ONE);
                chk("t1_unit_b", as_unit_b, TWO);
                chk("t1_unit_sub", 80'(as_unit_sub), 80'h0);
            end
            if (k == 8) chk("t1_done_early", 80'(as_done), 80'h0);
            if (k == 9) begin
                chk("t1_done", 80'(as_done), 80'h2);
                chk("t1_result", as_result, THREE);
                chk("t1_flags", 80'(as_flags), 80'h0);
            end
        end
        chk("t1_en_count", 80'(nen), 80'h1);
        as_fix = 1'b0;

        // T2: all three MulDiv requesters on the same edge
        exp_md_res[0] = 80'hA000_0000_0000_0000_00F1; exp_md_flg[0] = 4'h1;
        exp_md_res[1] = 80'hB000_0000_0000_0000_0F02; exp_md_flg[1] = 4'h2;
        exp_md_res[2] = 80'hC000_0000_0000_0000_F004; exp_md_flg[2] = 4'h4;
        md_a[0   +: 80] = 80'hA000_0000_0000_0000_0001; md_b[0   +: 80] = 80'h0000_0000_0000_0000_00F0;
        md_a[80  +: 80] = 80'hB000_0000_0000_0000_0002; md_b[80  +: 80] = 80'h0000_0000_0000_0000_0F00;
        md_a[160 +: 80] = 80'hC000_0000_0000_0000_0004; md_b[160 +: 80] = 80'h0000_0000_0000_0000_F000;
        md_div = 3'b101; md_req = 3'b111; md_lat = 1; ng = 0; nd = 0;
        for (int k = 0; k < 80 && nd < 3; k++) begin
            @(negedge clk);
            md_req = '0;
            if (md_unit_enable && ng < 3) begin got_div[ng] = md_unit_div; ng++; end
            if (md_done != '0) begin
                got_done[nd] = md_done; got_res[nd] = md_result; got_flg[nd] = md_flags; nd++;
            end
        end
        chk("t2_ndone", 80'(nd), 80'h3);
        for (int j = 0; j < nd; j++) begin
            chk($sformatf("t2_done%0d", j), 80'(got_done[j]), 80'(3'b001 << j));
            chk($sformatf("t2_res%0d", j), got_res[j], exp_md_res[j]);
            chk($sformatf("t2_flg%0d", j), 80'(got_flg[j]), 80'(exp_md_flg[j]));
            chk($sformatf("t2_div%0d", j), 80'(got_div[j]), 80'(j != 1));
        end

        // T3: round-robin, requesters 0 and 2 re-request as soon as granted
        do_reset();
        as_lat = 2; ng = 0; nperr = 0;
        as_a[0 +: 80] = 80'h10; as_a[160 +: 80] = 80'h30;
        as_req = 3'b101;
        for (int k = 0; k < 200 && ng < 6; k++) begin
            @(negedge clk);
            as_req = '0;
            if (protocol_err) nperr++;
            if (as_unit_enable) begin
                glog[ng] = (as_unit_a == 80'h10) ? 0 : 2;
                if (ng < 5) as_req[glog[ng]] = 1'b1;
                ng++;
            end
        end
        repeat (20) @(negedge clk);
        chk("t3_ngrant", 80'(ng), 80'h6);
        for (int j = 0; j < ng; j++)
            chk($sformatf("t3_grant%0d", j), 80'(glog[j]), 80'((j % 2) * 2));
        chk("t3_perr", 80'(nperr), 80'h0);
        chk("t3_idle", 80'(as_busy), 80'h0);

        // T4a: requester 0 pulses twice while its slot is pending
        as_lat = 10; nperr = 0; ndone = 0; r0 = '0; nen = 0;
        as_a[80 +: 80] = 80'h1; as_req = 3'b010;
        @(negedge clk); as_req = '0;
        repeat (4) @(negedge clk);
        as_a[0 +: 80] = 80'h5555_0000_0000_0000_0000; as_b[0 +: 80] = 80'h00FF; as_req = 3'b001;
        @(negedge clk);
        if (protocol_err) nperr++;
        as_a[0 +: 80] = 80'h6666_0000_0000_0000_0000; as_req = 3'b001;
        for (int k = 0; k < 80 && ndone == 0; k++) begin
            @(negedge clk);
            as_req = '0;
            if (protocol_err) nperr++;
            if (as_unit_enable && as_unit_a != 80'h1) r0 = as_unit_a;
            if (as_done == 3'b001) begin ndone++; chk("t4_result", as_result, 80'h5555_0000_0000_0000_00FF); end
        end
        chk("t4_perr_count", 80'(nperr), 80'h1);
        chk("t4_unit_a", r0, 80'h5555_0000_0000_0000_0000);
        chk("t4_done_seen", 80'(ndone), 80'h1);

        // T4b: request lands on the same edge its slot is granted -> not an error
        as_lat = 2; nperr = 0; nen = 0;
        repeat (3) @(negedge clk);
        as_a[0 +: 80] = 80'hA1; as_req = 3'b001;
        @(negedge clk);
        as_a[0 +: 80] = 80'hA2; as_req = 3'b001;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            as_req = '0;
            if (protocol_err) nperr++;
            if (as_unit_enable && nen < 4) begin ua_log[nen] = as_unit_a; nen++; end
        end
        chk("t4b_perr", 80'(nperr), 80'h0);
        chk("t4b_nen", 80'(nen), 80'h2);
        chk("t4b_first", ua_log[0], 80'hA1);
        chk("t4b_second", ua_log[1], 80'hA2);

        // T5: watchdog on AddSub requester 2, late stray unit_done ignored
        as_mode = 1; ndone = 0;
        as_a[160 +: 80] = 80'h7; as_req = 3'b100;
        for (int k = 1; k <= TO + 4; k++) begin
            @(negedge clk);
            as_req = '0;
            if (k == TO + 3) chk("t5_done_early", 80'(as_done), 80'h0);
            if (k == TO + 4) begin
                chk("t5_done", 80'(as_done), 80'h4);
                chk("t5_result", as_result, INDEF);
                chk("t5_flags", 80'(as_flags), 80'h8);
            end
        end
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (as_done != '0) ndone++;
        end
        chk("t5_stray_ignored", 80'(ndone), 80'h0);
        chk("t5_idle", 80'(as_busy), 80'h0);
        as_mode = 0;

        // T6: reset during MulDiv WAIT, then a fresh request
        md_mode = 2;
        md_a[80 +: 80] = 80'h99; md_req = 3'b010;
        @(negedge clk); md_req = '0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t6_md_busy", 80'(md_busy), 80'h0);
        chk("t6_md_unit_a", md_unit_a, 80'h0);
        chk("t6_md_en", 80'(md_unit_enable), 80'h0);
        chk("t6_as_result", as_result, 80'h0);
        chk("t6_as_flags", 80'(as_flags), 80'h0);
        chk("t6_md_done", 80'(md_done), 80'h0);
        @(negedge clk);
        reset_n = 1'b1; md_mode = 0; md_lat = 3; ndone = 0;
        @(negedge clk);
        md_a[80 +: 80] = 80'h1234_0000_0000_0000_0000; md_b[80 +: 80] = 80'h00AB; md_req = 3'b010;
        for (int k = 0; k < 40 && ndone == 0; k++) begin
            @(negedge clk);
            md_req = '0;
            if (md_done != '0) begin
                ndone++;
                chk("t6_done", 80'(md_done), 80'h2);
                chk("t6_result", md_result, 80'h1234_0000_0000_0000_00AB);
            end
        end
        chk("t6_done_seen", 80'(ndone), 80'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fpu_shared_unit_arbiter.md
# fpu_shared_unit_arbiter

Arbitrates the single shared FPU AddSub unit and the single shared MulDiv unit between NREQ requesters: the main arithmetic path, the polynomial evaluator and the transcendental sequencer. Each requester issues one-cycle request pulses with operands. The arbiter latches each request and serves requesters round-robin, one operation per unit at a time. It routes the unit's result and exception flags back as a one-cycle done pulse to the requester that owns the operation. A watchdog completes hung operations with the x87 indefinite value.

## Interface
- NREQ, 3: number of requesters; index 0 is highest in the initial round-robin order.
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before watchdog completion; 16-bit counter.

Ports. The AddSub side uses prefix as_ and operation bit as_sub. The MulDiv side uses prefix md_ and operation bit md_div (1 = divide). Both sides are otherwise identical.
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- as_req / md_req  in  NREQ  per-requester one-cycle request pulse.
- as_a, as_b / md_a, md_b  in  NREQ*80  packed operands; requester i occupies bits [80i+79:80i].
- as_sub / md_div  in  NREQ  per-requester operation bit.
- as_done / md_done  out  NREQ  one-hot one-cycle completion pulse.
- as_result / md_result  out  80  registered result, broadcast; valid only with done.
- as_flags / md_flags  out  4  {invalid, overflow, underflow, inexact}, valid with done.
- as_unit_enable / md_unit_enable  out  1  one-cycle start pulse to the shared unit.
- as_unit_a, as_unit_b / md_unit_a, md_unit_b  out  80  operands to the unit.
- as_unit_sub / md_unit_div  out  1  operation bit to the unit.
- as_unit_result / md_unit_result  in  80  unit result.
- as_unit_done / md_unit_done  in  1  unit completion pulse.
- as_unit_flags / md_unit_flags  in  4  unit flags, same order as *_flags.
- as_busy / md_busy  out  1  high when the state is not IDLE or any pending bit is set.
- protocol_err  out  1  one-cycle pulse when any request is rejected.

## Operation
- The two unit sides are fully independent and instantiate identical logic.
- Each requester has one pending slot per side, holding a valid bit, two 80-bit operands and the op bit.
- A request pulse on requester i is captured when slot i is empty.
- A request pulse on requester i when slot i is already valid is dropped, the stored slot is unchanged, and protocol_err pulses the next cycle.
- A requester whose operation is in flight but whose slot is empty may queue one more operation.
- State machine per side:
  - IDLE: if any slot is valid, pick the first valid index searching from ptr+1 modulo NREQ. Latch that grant index, drive the unit operands and op bit, assert unit_enable, clear the slot valid bit, set ptr to the grant index, and go to ISSUE.
  - ISSUE: deassert unit_enable, clear the watchdog counter, go to WAIT.
  - WAIT: the counter increments each cycle.
    - On unit_done: register unit_result and unit_flags into result/flags, pulse done[grant], go to IDLE.
    - When the counter reaches TIMEOUT_CYCLES without unit_done: result = 80'hFFFF_C000_0000_0000_0000, flags = 4'b1000, pulse done[grant], go to IDLE.
- unit_done received in IDLE or ISSUE is ignored.
- A request captured on the same edge that its slot is cleared by grant is a new operation; it is not a protocol error.
- Reset, asynchronous and at any time, including mid-operation: all state returns to IDLE, all slots are cleared, ptr = NREQ-1, and every output goes to 0. This includes unit_enable, unit operands, done, result, flags, busy and protocol_err.

## Timing
- A request sampled at edge E0 fills its slot after E0.
- If the side is idle, the grant decision is made at E1 and unit_enable is high for exactly one cycle, E1 to E2.
- unit_done sampled at edge Ed produces done and result valid from Ed to Ed+1.
- The next grant happens at Ed+1 at the earliest, giving one idle cycle between operations.
- Minimum request-to-done latency: unit latency + 3 cycles.
- Watchdog completion asserts done TIMEOUT_CYCLES+1 cycles after the ISSUE cycle.
- done is never asserted on two requesters in the same cycle within one side. The AddSub and MulDiv sides may each assert done in the same cycle.

## Test plan
- Single requester 1 on AddSub: a=1.0 (3FFF8000000000000000), b=2.0, sub=0, unit model latency 5. Required: as_unit_enable pulses once; as_done = 3'b010 with result 4000C000000000000000 at cycle E0+8.
- All three requesters pulse md_req on the same edge. Required: grants in order 0,1,2; each md_done is one-hot to the matching requester; results are not mixed up between requesters.
- Round-robin fairness: requesters 0 and 2 request back-to-back continuously. Required: grants alternate 0,2,0,2; neither requester is starved.
- Requester 0 pulses twice while its slot is still pending. Required: the second request is dropped, protocol_err pulses once, and the first operation's operands reach the unit.
- Unit model never asserts done. Required: after TIMEOUT_CYCLES+1 cycles, done fires with result FFFFC000000000000000 and flags 4'b1000; a later stray unit_done is ignored.
- reset_n asserted during WAIT. Required: all outputs are 0 immediately; after release, a fresh request completes normally.
